// File: rtl/sseg_scan_controller.sv
// Scan controller for a multiplexed common-anode 7-segment display with frame-aligned loads.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module sseg_scan_controller #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     en_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [N_DIGITS-1:0]     AN,
  output logic [6:0]              sseg,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] BlankEnd  = PW'(BLANK_CYCLES);

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan position
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          presc_last, idx_last, boundary;

  // Handshake and display content
  logic                  pending_q, pending_d;
  logic                  accept, commit;
  logic [4*N_DIGITS-1:0] stage_val_q, active_val_q;
  logic [N_DIGITS-1:0]   stage_dp_q, active_dp_q;
  logic [N_DIGITS-1:0]   stage_en_q, active_en_q;
  logic [N_DIGITS-1:0]   lz_mask_q;

  // Registered outputs
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          sseg_q, sseg_d;
  logic                dp_q, dp_d;
  logic                boundary_q, fs_q;

  always_comb begin
    presc_last = (presc_q == PrescLast);
    idx_last   = (idx_q == IdxLast);
    boundary   = presc_last && idx_last;
    presc_d    = presc_last ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    if (presc_last) begin
      idx_d = idx_last ? '0 : idx_q + IW'(1);
    end
  end

  assign load_ready = ~pending_q;
  assign accept     = load_valid && ~pending_q;
  // Ready is the inverse of pending, so accept and commit are mutually exclusive.
  assign commit     = boundary && pending_q;

  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      stage_val_q  <= '0;
      stage_dp_q   <= '0;
      stage_en_q   <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      active_en_q  <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      if (accept) begin
        stage_val_q <= value_in;
        stage_dp_q  <= dp_in;
        stage_en_q  <= en_in;
      end
      if (commit) begin
        active_val_q <= stage_val_q;
        active_dp_q  <= stage_dp_q;
        active_en_q  <= stage_en_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask_d;
  logic                zero_run;

  // Walk down from the top digit; disabled digits do not break a run of leading zeros.
  always_comb begin
    lz_mask_d = '0;
    zero_run  = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      if (stage_en_q[k]) begin
        zero_run = zero_run && (stage_val_q[4*k +: 4] == 4'h0);
      end
      lz_mask_d[k] = zero_run;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lz_mask_q <= '0;
    end else if (commit) begin
      lz_mask_q <= lz_mask_d;
    end
  end
`else
  assign lz_mask_q = '0;
`endif

  logic [3:0] cur_nib;
  logic       cur_dp;

  always_comb begin
    an_d    = '1;
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib = active_val_q[4*k +: 4];
        cur_dp  = active_dp_q[k];
        if ((presc_q >= BlankEnd) && active_en_q[k] && !lz_mask_q[k]) begin
          an_d[k] = 1'b0;
        end
      end
    end
    sseg_d = hex7(cur_nib);
    dp_d   = ~cur_dp;
  end

  // frame_start is delayed two stages from the boundary so it lines up with the
  // first registered output of the digit 0 slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q       <= '1;
      sseg_q     <= 7'h7F;
      dp_q       <= 1'b1;
      boundary_q <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      dp_q       <= dp_d;
      boundary_q <= boundary;
      fs_q       <= boundary_q;
    end
  end

  assign AN          = an_q;
  assign sseg        = sseg_q;
  assign DP          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed self-checking bench for sseg_scan_controller (8 digits, 8-cycle slots, 2 blank).
module tb_sseg_scan_controller;

  localparam int N  = 8;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] SegTab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4*N-1:0] value_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  en_in = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [N-1:0]  AN;
  logic [6:0]    sseg;
  logic          DP;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  sseg_scan_controller #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .AN         (AN),
    .sseg       (sseg),
    .DP         (DP),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    value_in   = v;
    dp_in      = d;
    en_in      = e;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    repeat (2) @(negedge clk);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL rst_an got %h want ff", AN); end
    checks++; if (sseg !== 7'h7F) begin errors++; $display("FAIL rst_sseg got %h want 7f", sseg); end
    checks++; if (DP !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", DP); end
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", load_ready); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got %b want 0", frame_start); end
    reset = 1'b0;
    // 64-cycle frame plus the output register stage
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL idle_first_fs got %0d want 65", n); end
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL idle_an got %h want ff", AN); end
    checks++; if (DP !== 1'b1) begin errors++; $display("FAIL idle_dp got %b want 1", DP); end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL idle_period got %0d want 64", n); end
  endtask

  task automatic test_load;
    bit ok;
    wait_fs(ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_sync got 0 want 1"); end
    load(32'h0123_89AF, 8'h01, 8'hFF);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL load_busy got %b want 0", load_ready); end
    wait_fs(ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_fs got 0 want 1"); end
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL load_free got %b want 1", load_ready); end
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL d0_blank_an got %h want ff", AN); end
    checks++; if (sseg !== 7'h0E) begin errors++; $display("FAIL d0_blank_sseg got %h want 0e", sseg); end
    skip(BC);
    checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL d0_an got %h want fe", AN); end
    checks++; if (sseg !== 7'h0E) begin errors++; $display("FAIL d0_sseg got %h want 0e", sseg); end
    checks++; if (DP !== 1'b0) begin errors++; $display("FAIL d0_dp got %b want 0", DP); end
    skip(RD);
    checks++; if (AN !== 8'hFD) begin errors++; $display("FAIL d1_an got %h want fd", AN); end
    checks++; if (sseg !== 7'h08) begin errors++; $display("FAIL d1_sseg got %h want 08", sseg); end
    checks++; if (DP !== 1'b1) begin errors++; $display("FAIL d1_dp got %b want 1", DP); end
    skip(6 * RD);
    checks++; if (AN !== 8'h7F) begin errors++; $display("FAIL d7_an got %h want 7f", AN); end
    checks++; if (sseg !== 7'h40) begin errors++; $display("FAIL d7_sseg got %h want 40", sseg); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    wait_fs(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_sync got 0 want 1"); end
    load(32'h0000_0003, 8'h00, 8'hFF);
    value_in   = 32'h0000_0007;
    load_valid = 1'b1;
    skip(5);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_held got %b want 0", load_ready); end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (load_ready) break;
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL b2b_ready_timeout got %0d want <200", n); end
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_fs got %b want 1", frame_start); end
    checks++; if (sseg !== 7'h30) begin errors++; $display("FAIL b2b_first got %h want 30", sseg); end
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_acc got %b want 0", load_ready); end
    wait_fs(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_fs2 got 0 want 1"); end
    checks++; if (sseg !== 7'h78) begin errors++; $display("FAIL b2b_second got %h want 78", sseg); end
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_free got %b want 1", load_ready); end
  endtask

  task automatic test_enable;
    bit ok;
    logic [31:0] v;
    logic [7:0]  exp_an;
    int d, p;
    v = 32'h7654_3210;
    wait_fs(ok);
    load(v, 8'h00, 8'h0F);
    wait_fs(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_fs got 0 want 1"); end
    for (int s = 0; s < N * RD; s++) begin
      if (s > 0) @(negedge clk);
      d = s / RD;
      p = s % RD;
      exp_an = 8'hFF;
      if (d < 4 && p >= BC) exp_an[d] = 1'b0;
      checks++;
      if (AN !== exp_an) begin
        errors++; $display("FAIL en_an d%0d p%0d got %h want %h", d, p, AN, exp_an);
      end
      checks++;
      if (sseg !== SegTab[v[4*d +: 4]]) begin
        errors++; $display("FAIL en_sseg d%0d got %h want %h", d, sseg, SegTab[v[4*d +: 4]]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    wait_fs(ok);
    load(32'hFFFF_FFFF, 8'hFF, 8'hFF);
    skip(10);
    reset = 1'b1;
    #1;
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL mid_an got %h want ff", AN); end
    checks++; if (sseg !== 7'h7F) begin errors++; $display("FAIL mid_sseg got %h want 7f", sseg); end
    checks++; if (DP !== 1'b1) begin errors++; $display("FAIL mid_dp got %b want 1", DP); end
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", load_ready); end
    skip(2);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL mid_fs got %0d want 65", n); end
    skip(BC);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL mid_dark got %h want ff", AN); end
    checks++; if (sseg !== 7'h40) begin errors++; $display("FAIL mid_discard got %h want 40", sseg); end
  endtask

  task automatic test_lzb;
    bit ok;
    logic [31:0] vals [2];
    logic [7:0]  exp_an;
    bit lit;
    vals[0] = 32'h0000_0050;
    vals[1] = 32'h0000_0000;
    for (int t = 0; t < 2; t++) begin
      wait_fs(ok);
      load(vals[t], 8'h00, 8'hFF);
      wait_fs(ok);
      checks++; if (!ok) begin errors++; $display("FAIL lzb_fs%0d got 0 want 1", t); end
      skip(BC);
      checks++; if (sseg !== 7'h40) begin errors++; $display("FAIL lzb_d0_sseg got %h want 40", sseg); end
      for (int d = 0; d < N; d++) begin
        if (d > 0) skip(RD);
`ifdef LEADING_ZERO_BLANK_EN
        lit = (t == 0) ? (d <= 1) : (d == 0);
`else
        lit = 1'b1;
`endif
        exp_an = 8'hFF;
        if (lit) exp_an[d] = 1'b0;
        checks++;
        if (AN !== exp_an) begin
          errors++; $display("FAIL lzb_an v%0d d%0d got %h want %h", t, d, AN, exp_an);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_lzb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
